// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: round-robin writer and FIFO reader for a 32-entry instruction register stack; INSTR_REG_CTRL_STATS_EN adds accept/drop counters
package instr_reg_pkg;
  typedef enum logic [1:0] {ZERO, ADD, SUB, MULT} opcode_t;
  typedef logic signed [7:0] operand_t;
  typedef logic [4:0] address_t;
  typedef struct packed {
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;
  } instruction_t;
endpackage

module instr_reg_ctrl
  import instr_reg_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  opcode_t            req0_opcode,
  input  operand_t           req0_operand_a,
  input  operand_t           req0_operand_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  opcode_t            req1_opcode,
  input  operand_t           req1_operand_a,
  input  operand_t           req1_operand_b,
  input  logic               rd_req,
  output logic               rd_resp_valid,
  output instruction_t       rd_resp_instr,
  output logic               load_en,
  output address_t           write_pointer,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
`ifdef INSTR_REG_CTRL_STATS_EN
  ,
  output logic [15:0]        wr0_cnt,
  output logic [15:0]        wr1_cnt,
  output logic [15:0]        drop_cnt
`endif
);
  typedef enum logic {IDLE, CAPTURE} state_t;
  state_t state, state_nxt;
  address_t wr_ptr, rd_ptr;
  logic prio1, acc0, acc1, acc, pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign req0_ready = !full && req0_valid && (!req1_valid || !prio1);
  assign req1_ready = !full && req1_valid && (!req0_valid || prio1);
  assign acc0 = req0_valid && req0_ready;
  assign acc1 = req1_valid && req1_ready;
  assign acc = acc0 || acc1;
  assign pop = state == IDLE && rd_req && !empty;
  always_comb begin
    state_nxt = state;
    state_nxt = state == CAPTURE ? IDLE : (pop ? CAPTURE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      load_en <= 1'b0;
      write_pointer <= '0;
      read_pointer <= '1;
      opcode <= ZERO;
      operand_a <= '0;
      operand_b <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_instr <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      prio1 <= 1'b0;
    end else begin
      load_en <= acc;
      rd_resp_valid <= state == CAPTURE;
      count <= count + CNT_W'(acc) - CNT_W'(pop);
      if (acc) begin
        write_pointer <= wr_ptr;
        opcode <= acc1 ? req1_opcode : req0_opcode;
        operand_a <= acc1 ? req1_operand_a : req0_operand_a;
        operand_b <= acc1 ? req1_operand_b : req0_operand_b;
        wr_ptr <= wr_ptr + 1'b1;
        prio1 <= acc0;
      end
      if (pop) begin
        read_pointer <= rd_ptr;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == CAPTURE) rd_resp_instr <= instruction_word;
    end
  end
`ifdef INSTR_REG_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr0_cnt <= '0;
      wr1_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (acc0 && wr0_cnt != 16'hFFFF) wr0_cnt <= wr0_cnt + 1'b1;
      if (acc1 && wr1_cnt != 16'hFFFF) wr1_cnt <= wr1_cnt + 1'b1;
      if (state == IDLE && rd_req && empty && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_reg_ctrl.sv
// tb_instr_reg_ctrl: vector table plus FIFO scoreboard for instr_reg_ctrl, with a behavioural register stack
module tb_instr_reg_ctrl;
  import instr_reg_pkg::*;
  logic clk, reset, req0_valid, req1_valid, req0_ready, req1_ready, rd_req, rd_resp_valid, load_en, full, empty;
  instruction_t d0, d1, rd_resp_instr, instruction_word;
  address_t write_pointer, read_pointer;
  opcode_t opcode;
  operand_t operand_a, operand_b;
  logic [5:0] count;
`ifdef INSTR_REG_CTRL_STATS_EN
  logic [15:0] wr0_cnt, wr1_cnt, drop_cnt;
`endif
  instruction_t mem [32];
  instruction_t sb [$];
  int checks = 0, errors = 0, resp_n = 0;

  instr_reg_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(d0.opcode),
    .req0_operand_a(d0.operand_a), .req0_operand_b(d0.operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(d1.opcode),
    .req1_operand_a(d1.operand_a), .req1_operand_b(d1.operand_b),
    .rd_req(rd_req), .rd_resp_valid(rd_resp_valid), .rd_resp_instr(rd_resp_instr),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .count(count), .full(full), .empty(empty)
`ifdef INSTR_REG_CTRL_STATS_EN
    , .wr0_cnt(wr0_cnt), .wr1_cnt(wr1_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  assign instruction_word = mem[read_pointer];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rd_resp_valid) begin
    resp_n++;
    if (sb.size() == 0) chk("unexpected_resp", 32'(rd_resp_valid), 0);
    else chk("resp_instr", 32'(rd_resp_instr), 32'(sb.pop_front()));
  end

  typedef struct {
    logic v0, v1;
    instruction_t d0, d1;
    logic r0, r1;
    int wp, cnt;
  } vec_t;
  vec_t tbl [7];

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    mk = '{o, operand_t'(a), operand_t'(b)};
  endfunction

  function automatic vec_t row(input logic v0, input logic v1, input instruction_t x0, input instruction_t x1,
                               input logic r0, input logic r1, input int wp, input int cnt);
    row = '{v0: v0, v1: v1, d0: x0, d1: x1, r0: r0, r1: r1, wp: wp, cnt: cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rd_req = 1'b0;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t t);
    instruction_t e;
    req0_valid = t.v0;
    req1_valid = t.v1;
    d0 = t.d0;
    d1 = t.d1;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(t.r0));
    chk("req1_ready", 32'(req1_ready), 32'(t.r1));
    e = t.r0 ? t.d0 : t.d1;
    if (t.r0 || t.r1) sb.push_back(e);
    tick();
    chk("load_en", 32'(load_en), 32'(t.r0 || t.r1));
    chk("write_pointer", 32'(write_pointer), t.wp);
    chk("wr_data", 32'({opcode, operand_a, operand_b}), 32'(e));
    chk("count", 32'(count), t.cnt);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    d0 = '0;
    d1 = '0;
    tbl[0] = row(1, 0, mk(ADD, 3, 5), mk(ZERO, 0, 0), 1, 0, 0, 1);
    tbl[1] = row(1, 0, mk(SUB, 7, 2), mk(ZERO, 0, 0), 1, 0, 1, 2);
    tbl[2] = row(1, 0, mk(MULT, -4, 9), mk(ZERO, 0, 0), 1, 0, 2, 3);
    tbl[3] = row(1, 1, mk(ADD, 1, 1), mk(SUB, 2, 2), 1, 0, 0, 1);
    tbl[4] = row(1, 1, mk(ADD, 3, 3), mk(SUB, 4, 4), 0, 1, 1, 2);
    tbl[5] = row(1, 1, mk(MULT, 5, 5), mk(ADD, 6, 6), 1, 0, 2, 3);
    tbl[6] = row(1, 1, mk(SUB, 7, 7), mk(MULT, 8, 8), 0, 1, 3, 4);

    reset_dut();
    chk("rst_load_en", 32'(load_en), 0);
    chk("rst_write_pointer", 32'(write_pointer), 0);
    chk("rst_read_pointer", 32'(read_pointer), 31);
    chk("rst_wr_data", 32'({opcode, operand_a, operand_b}), 0);
    chk("rst_resp", 32'({rd_resp_valid, rd_resp_instr}), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", 32'({full, empty}), 1);

    for (int i = 0; i < 3; i++) apply(tbl[i]);
    req0_valid = 1'b0;
    rd_req = 1'b1;
    r = resp_n;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("pop_resp_valid", 32'(rd_resp_valid), 32'(k % 2));
      if (k % 2 == 0) begin
        chk("pop_read_pointer", 32'(read_pointer), k / 2);
        chk("pop_count", 32'(count), 2 - k / 2);
      end
    end
    rd_req = 1'b0;
    tick();
    chk("pop_resp_total", resp_n - r, 3);
    chk("pop_empty", 32'(empty), 1);

    reset_dut();
    for (int i = 3; i < 7; i++) apply(tbl[i]);

    req1_valid = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 28; i++) begin
      d0 = mk(opcode_t'(i % 4), i, -i);
      sb.push_back(d0);
      tick();
    end
    chk("fill_count", 32'(count), 32);
    chk("fill_full", 32'(full), 1);
    req1_valid = 1'b1;
    d1 = mk(ADD, -1, -1);
    #1;
    chk("full_readys", 32'({req0_ready, req1_ready}), 0);
    tick();
    chk("full_no_load", 32'(load_en), 0);
    chk("full_count", 32'(count), 32);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("free_read_pointer", 32'(read_pointer), 0);
    chk("free_count", 32'(count), 31);
    #1;
    chk("free_readys", 32'({req0_ready, req1_ready}), 1);
    sb.push_back(d1);
    tick();
    chk("refill_load", 32'(load_en), 1);
    chk("refill_write_pointer", 32'(write_pointer), 0);
    chk("refill_data", 32'({opcode, operand_a, operand_b}), 32'(d1));
    chk("refill_count", 32'(count), 32);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    reset_dut();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("drop_count", 32'(count), 0);
    tick();
    chk("drop_no_resp", 32'(rd_resp_valid), 0);
`ifdef INSTR_REG_CTRL_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 1);
`endif
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d1 = mk(SUB, 10 + i, i);
      sb.push_back(d1);
      tick();
    end
    chk("five_count", 32'(count), 5);
    d1 = mk(MULT, 20, 21);
    sb.push_back(d1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    req1_valid = 1'b0;
    chk("acc_pop_count", 32'(count), 5);
    chk("acc_pop_load", 32'(load_en), 1);
    tick();
    chk("acc_pop_resp", 32'(rd_resp_valid), 1);
    chk("acc_pop_count2", 32'(count), 5);
`ifdef INSTR_REG_CTRL_STATS_EN
    chk("wr1_cnt", 32'(wr1_cnt), 6);
    chk("wr0_cnt", 32'(wr0_cnt), 0);
`endif

    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("cap_count", 32'(count), 4);
    reset = 1'b1;
    req0_valid = 1'b1;
    d0 = mk(ADD, 9, 9);
    sb.delete();
    tick();
    chk("rst_cap_resp", 32'(rd_resp_valid), 0);
    chk("rst_cap_load", 32'(load_en), 0);
    reset = 1'b0;
    sb.push_back(d0);
    tick();
    chk("post_rst_resp", 32'(rd_resp_valid), 0);
    chk("post_rst_write_pointer", 32'(write_pointer), 0);
    chk("post_rst_load", 32'(load_en), 1);
    chk("post_rst_count", 32'(count), 1);
    req0_valid = 1'b0;
    tick();
    chk("post_rst_read_pointer", 32'(read_pointer), 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
